// File: rtl/mem_access_ctrl_pkg.sv
// Shared encodings and byte-enable helper for the data-memory access unit.
package mem_pkg;

    localparam logic [1:0] MEM_SZ_B = 2'd0;
    localparam logic [1:0] MEM_SZ_H = 2'd1;
    localparam logic [1:0] MEM_SZ_W = 2'd2;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    function automatic logic [3:0] mem_byte_en(input logic [1:0] size, input logic [1:0] offset);
        case (size)
            MEM_SZ_B: return 4'b0001 << offset;
            MEM_SZ_H: return offset[1] ? 4'b1100 : 4'b0011;
            MEM_SZ_W: return 4'b1111;
            default:  return 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_ctrl_lane_align.sv
// Store-lane replication with byte enables, and load-lane extraction with sign/zero extension.
module mem_lane_align
    import mem_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  offset,
    input  logic        zero_ext,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [31:0] wlanes,
    output logic [3:0]  byte_en,
    output logic [31:0] rdata
);

    logic [31:0] shifted;
    logic        fill;

    always_comb begin
        shifted = rword >> {offset, 3'b000};
        fill    = 1'b0;
        wlanes  = wdata;
        rdata   = rword;
        byte_en = mem_byte_en(size, offset);
        case (size)
            MEM_SZ_B: begin
                fill   = ~zero_ext & shifted[7];
                wlanes = {4{wdata[7:0]}};
                rdata  = {{24{fill}}, shifted[7:0]};
            end
            MEM_SZ_H: begin
                fill   = ~zero_ext & shifted[15];
                wlanes = {2{wdata[15:0]}};
                rdata  = {{16{fill}}, shifted[15:0]};
            end
            default: begin
                wlanes = wdata;
                rdata  = rword;
            end
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Data-memory access unit: serialised byte/half/word loads and stores to a local word RAM.
module mem_access_ctrl
    import mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int ADDR_W      = 32,
    parameter int LATENCY     = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic              rsp_err,
    output logic [31:0]       rsp_rdata,
    output logic              stat_mem_read_done,
    output logic              stat_mem_write_done
);

    localparam int         IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [3:0] LAT   = 4'(LATENCY);

    logic [1:0]        state;
    logic [3:0]        cnt;
    logic [3:0]        cnt_nxt;
    logic              commit;

    logic              we_p0;
    logic              uns_p0;
    logic [1:0]        size_p0;
    logic [ADDR_W-1:0] addr_p0;
    logic [31:0]       wdata_p0;

    logic              err_p1;
    logic [31:0]       rdata_p1;

    logic [31:0]       mem [DEPTH_WORDS];

    logic [IDX_W-1:0]  idx;
    logic              range_err;
    logic              access_err;
    logic [31:0]       wlanes;
    logic [3:0]        byte_en;
    logic [31:0]       ld_data;

    assign cnt_nxt = cnt + 4'd1;
    assign commit  = (state == ST_WAIT) && (cnt_nxt == LAT);

    assign idx        = addr_p0[2 +: IDX_W];
    assign range_err  = |(addr_p0 >> (2 + IDX_W));
    assign access_err = range_err
                      | (size_p0 == 2'd3)
                      | ((size_p0 == MEM_SZ_H) & addr_p0[0])
                      | ((size_p0 == MEM_SZ_W) & (|addr_p0[1:0]));

    mem_lane_align u_lane (
        .size     (size_p0),
        .offset   (addr_p0[1:0]),
        .zero_ext (uns_p0),
        .wdata    (wdata_p0),
        .rword    (mem[idx]),
        .wlanes   (wlanes),
        .byte_en  (byte_en),
        .rdata    (ld_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= 4'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    cnt <= 4'd0;
                    if (req_valid) state <= ST_WAIT;
                end
                ST_WAIT: begin
                    cnt <= cnt_nxt;
                    if (commit) state <= ST_RESP;
                end
                ST_RESP: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // p0: request capture on acceptance
    always_ff @(posedge clk) begin
        if (state == ST_IDLE && req_valid) begin
            we_p0    <= req_we;
            uns_p0   <= req_unsigned;
            size_p0  <= req_size;
            addr_p0  <= req_addr;
            wdata_p0 <= req_wdata;
        end
    end

    // p1: checked result registered on the commit edge
    always_ff @(posedge clk) begin
        if (commit) begin
            err_p1   <= access_err;
            rdata_p1 <= (access_err || we_p0) ? 32'd0 : ld_data;
        end
    end

    // Reset on the commit edge drops the store entirely.
    always_ff @(posedge clk) begin
        if (commit && !rst && we_p0 && !access_err) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en[b]) mem[idx][8*b +: 8] <= wlanes[8*b +: 8];
            end
        end
    end

    assign req_ready           = (state == ST_IDLE) & ~rst;
    assign rsp_valid           = (state == ST_RESP) & ~rst;
    assign rsp_err             = rsp_valid & err_p1;
    assign rsp_rdata           = rsp_valid ? rdata_p1 : 32'd0;
    assign stat_mem_read_done  = rsp_valid & ~we_p0 & ~err_p1;
    assign stat_mem_write_done = rsp_valid & we_p0 & ~err_p1;

endmodule
